// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a sync_fifo.
// Grants one producer at a time for bursts of up to MAX_BURST words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t             state_q, state_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [PW-1:0]      own_q, own_n;
  logic [PW-1:0]      last_q, last_n;
  logic [BW-1:0]      cnt_q, cnt_n;
  logic [PW-1:0]      win;
  logic               wr;
  logic               cap_hit;

  assign wr      = (state_q == BURST) & req_i[own_q] & ~fifo_full_i;
  assign cap_hit = (cnt_q == BW'(MAX_BURST - 1));
  assign grant_o = grant_q;
  assign busy_o  = (state_q == BURST);

  // Winner: first pending request after the last owner, wrapping.
  always_comb begin
    logic found;
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_i[PW'((int'(last_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win   = PW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  // State register: owner, rotation pointer and burst count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      last_q  <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      own_q   <= own_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next state: grant on any request, release on cap or withdraw.
  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    own_n   = own_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_n = BURST;
          grant_n = NUM_REQ'(1) << win;
          own_n   = win;
          last_n  = win;
          cnt_n   = '0;
        end
      end
      BURST: begin
        if ((wr && cap_hit) || !req_i[own_q]) begin
          state_n = IDLE;
          grant_n = '0;
          cnt_n   = '0;
        end else if (wr) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs: pass the owner's word through while the FIFO has room.
  always_comb begin
    ack_o          = '0;
    fifo_wr_en_o   = 1'b0;
    fifo_wr_data_o = '0;
    if (state_q == BURST) begin
      fifo_wr_data_o = data_i[int'(own_q)*DATA_WIDTH +: DATA_WIDTH];
      fifo_wr_en_o   = wr;
      ack_o          = wr ? grant_q : '0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter with a behavioural 8-deep FIFO.
// Expected writes are queued by stimulus and popped by a monitor.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int MB    = 4;
  localparam int DEPTH = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [N-1:0]     req_i = '0;
  logic [N*W-1:0]   data_i = '0;
  logic [N-1:0]     ack_o;
  logic [N-1:0]     grant_o;
  logic             busy_o;
  logic             fifo_full_i = 1'b0;
  logic             fifo_wr_en_o;
  logic [W-1:0]     fifo_wr_data_o;

  fifo_wr_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(W),
    .MAX_BURST(MB)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .data_i(data_i),
    .ack_o(ack_o),
    .grant_o(grant_o),
    .busy_o(busy_o),
    .fifo_full_i(fifo_full_i),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_wr_data_o(fifo_wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         off;
    int         prod;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] pq[N][$];
  logic [W-1:0] fq[$];
  bit           force_full = 1'b0;
  bit           pop_en = 1'b0;
  bit [N-1:0]   pen = '0;
  int           cyc = 0;
  int           t0 = 0;
  int           checks = 0;
  int           errors = 0;
  logic         cap_wr = 1'b0;
  logic [N-1:0] cap_ack = '0;
  logic [W-1:0] cap_data = '0;

  function automatic void chk(bit ok, string nm,
                              logic [31:0] act, logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, req, cyc - t0);
    end
  endfunction

  function automatic void ex(int off, int p, logic [W-1:0] d);
    exp_t e;
    e.off  = off;
    e.prod = p;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_i[i] = pen[i] && (pq[i].size() > 0);
      data_i[i*W +: W] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    fifo_full_i = force_full || (fq.size() >= DEPTH);
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor: every presented write must match the head of exp_q.
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    cap_wr   = fifo_wr_en_o;
    cap_ack  = ack_o;
    cap_data = fifo_wr_data_o;
    if (fifo_wr_en_o) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_write", fifo_wr_data_o, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk(fifo_wr_data_o == e.data, "wr_data",
            fifo_wr_data_o, e.data);
        chk(ack_o == (N'(1) << e.prod), "ack",
            32'(ack_o), 32'(N'(1) << e.prod));
        if (e.off >= 0)
          chk((cyc - t0) == e.off, "wr_cycle",
              32'(cyc - t0), 32'(e.off));
      end
    end else begin
      chk(ack_o == '0, "ack_no_write", 32'(ack_o), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (cap_wr) begin
      chk(fq.size() < DEPTH, "no_overflow",
          32'(fq.size()), 32'(DEPTH - 1));
      fq.push_back(cap_data);
      for (int i = 0; i < N; i++)
        if (cap_ack[i] && pq[i].size() > 0)
          void'(pq[i].pop_front());
    end
    cap_wr  = 1'b0;
    cap_ack = '0;
    if (pop_en && fq.size() > 0)
      void'(fq.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    pen        = '0;
    force_full = 1'b0;
    pop_en     = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    fq.delete();
    drive();
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    t0 = cyc;
  endtask

  task automatic end_test(string nm);
    chk(exp_q.size() == 0, nm, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    // 1: reset holds everything idle even with all requests up
    pen = 4'b1111;
    for (int i = 0; i < N; i++) pq[i].push_back(32'h10 + 32'(i));
    drive();
    tick();
    chk(grant_o == '0, "rst_grant", 32'(grant_o), 32'h0);
    chk(ack_o == '0, "rst_ack", 32'(ack_o), 32'h0);
    chk(fifo_wr_en_o == 1'b0, "rst_wr_en", 32'(fifo_wr_en_o), 32'h0);
    chk(busy_o == 1'b0, "rst_busy", 32'(busy_o), 32'h0);
    for (int i = 0; i < N; i++) pq[i].delete();
    drive();
    rst_i = 1'b0;
    tick();
    tick();
    tick();
    chk(grant_o == '0, "idle_grant", 32'(grant_o), 32'h0);
    chk(busy_o == 1'b0, "idle_busy", 32'(busy_o), 32'h0);

    // 2: burst cap with a single producer
    do_reset();
    for (int k = 1; k <= 6; k++) pq[2].push_back(32'(k));
    ex(1, 2, 32'd1);
    ex(2, 2, 32'd2);
    ex(3, 2, 32'd3);
    ex(4, 2, 32'd4);
    ex(6, 2, 32'd5);
    ex(7, 2, 32'd6);
    pen = 4'b0100;
    drive();
    chk(grant_o == '0, "cap_grant0", 32'(grant_o), 32'h0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1)
        chk(grant_o == 4'b0100, "cap_grant1", 32'(grant_o), 32'h4);
      if (c == 5)
        chk(busy_o == 1'b0 && grant_o == '0, "cap_idle_gap",
            32'(grant_o), 32'h0);
      if (c == 6)
        chk(grant_o == 4'b0100, "cap_regrant", 32'(grant_o), 32'h4);
      if (c == 9)
        chk(busy_o == 1'b0, "cap_exit", 32'(busy_o), 32'h0);
    end
    chk(fq.size() == 6, "cap_fifo_cnt", 32'(fq.size()), 32'd6);
    for (int k = 1; k <= 6; k++)
      if (fq.size() > 0)
        chk(fq.pop_front() == 32'(k), "cap_fifo_pop", 32'(k), 32'(k));
    end_test("cap_leftover");

    // 3: round robin between producers 0, 1 and 3
    do_reset();
    pop_en = 1'b1;
    begin
      int ord[3] = '{0, 1, 3};
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 8; k++)
          pq[ord[i]].push_back(((ord[i] + 1) << 8) | k);
      for (int b = 0; b < 6; b++)
        for (int j = 0; j < 4; j++)
          ex(1 + b*5 + j, ord[b%3],
             ((ord[b%3] + 1) << 8) | ((b/3)*4 + j));
    end
    pen = 4'b1011;
    drive();
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c == 1)
        chk(grant_o == 4'b0001, "rr_g0", 32'(grant_o), 32'h1);
      if (c == 6)
        chk(grant_o == 4'b0010, "rr_g1", 32'(grant_o), 32'h2);
      if (c == 11)
        chk(grant_o == 4'b1000, "rr_g3", 32'(grant_o), 32'h8);
      if (c == 16)
        chk(grant_o == 4'b0001, "rr_g0b", 32'(grant_o), 32'h1);
    end
    end_test("rr_leftover");

    // 4: full stall in the middle of a burst
    do_reset();
    for (int k = 0; k < 4; k++) pq[0].push_back(32'hA0 + 32'(k));
    ex(1, 0, 32'hA0);
    ex(2, 0, 32'hA1);
    ex(6, 0, 32'hA2);
    ex(7, 0, 32'hA3);
    pen = 4'b0001;
    drive();
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 3) begin
        force_full = 1'b1;
        drive();
      end
      if (c == 4) begin
        chk(grant_o == 4'b0001, "full_grant", 32'(grant_o), 32'h1);
        chk(fifo_wr_en_o == 1'b0, "full_wr_en",
            32'(fifo_wr_en_o), 32'h0);
      end
      if (c == 5)
        chk(busy_o == 1'b1, "full_busy", 32'(busy_o), 32'h1);
      if (c == 6) begin
        force_full = 1'b0;
        drive();
      end
      if (c == 8)
        chk(busy_o == 1'b0, "full_exit", 32'(busy_o), 32'h0);
    end
    chk(fq.size() == 4, "full_total", 32'(fq.size()), 32'd4);
    end_test("full_leftover");

    // 5: owner withdraws, next producer takes over
    do_reset();
    pq[1].push_back(32'hB1);
    pq[3].push_back(32'hD1);
    pq[3].push_back(32'hD2);
    ex(1, 1, 32'hB1);
    ex(4, 3, 32'hD1);
    ex(5, 3, 32'hD2);
    pen = 4'b1010;
    drive();
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1 || c == 2)
        chk(grant_o == 4'b0010, "wd_owner", 32'(grant_o), 32'h2);
      if (c == 3)
        chk(grant_o == '0, "wd_idle", 32'(grant_o), 32'h0);
      if (c == 4)
        chk(grant_o == 4'b1000, "wd_next", 32'(grant_o), 32'h8);
    end
    end_test("wd_leftover");

    // 6: fill the FIFO, stall, then reset mid-stall
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++)
        pq[p].push_back(((p + 1) << 12) | k);
    for (int k = 0; k < 4; k++) ex(1 + k, 0, (1 << 12) | k);
    for (int k = 0; k < 4; k++) ex(6 + k, 1, (2 << 12) | k);
    pen = 4'b0111;
    drive();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 12) begin
        chk(grant_o == 4'b0100, "fill_stall_grant",
            32'(grant_o), 32'h4);
        chk(fifo_wr_en_o == 1'b0, "fill_stall_wr",
            32'(fifo_wr_en_o), 32'h0);
      end
    end
    chk(fq.size() == DEPTH, "fill_count", 32'(fq.size()), 32'(DEPTH));
    for (int k = 0; k < 8; k++)
      if (fq.size() > k)
        chk(fq[k] == (((k/4) + 1) << 12 | (k%4)), "fill_order",
            fq[k], ((k/4) + 1) << 12 | (k%4));
    end_test("fill_leftover");
    rst_i = 1'b1;
    #1;
    chk(grant_o == '0, "mid_rst_grant", 32'(grant_o), 32'h0);
    chk(busy_o == 1'b0, "mid_rst_busy", 32'(busy_o), 32'h0);
    chk(fifo_wr_en_o == 1'b0, "mid_rst_wr", 32'(fifo_wr_en_o), 32'h0);
    tick();
    fq.delete();
    pq[0].push_back(32'h0E01);
    pq[0].push_back(32'h0E02);
    ex(-1, 0, 32'h0E01);
    ex(-1, 0, 32'h0E02);
    for (int k = 0; k < 4; k++) ex(-1, 2, (3 << 12) | k);
    rst_i = 1'b0;
    t0 = cyc;
    drive();
    for (int c = 1; c <= 16; c++) tick();
    end_test("post_rst_leftover");

    // 7: reset while a word is being written
    do_reset();
    for (int k = 1; k <= 3; k++) pq[1].push_back(32'h70 + 32'(k));
    ex(1, 1, 32'h71);
    pen = 4'b0010;
    drive();
    tick();
    tick();
    chk(fifo_wr_en_o == 1'b1, "act_wr_before",
        32'(fifo_wr_en_o), 32'h1);
    rst_i = 1'b1;
    #1;
    chk(fifo_wr_en_o == 1'b0, "act_rst_wr", 32'(fifo_wr_en_o), 32'h0);
    chk(ack_o == '0, "act_rst_ack", 32'(ack_o), 32'h0);
    chk(fifo_wr_data_o == '0, "act_rst_data", fifo_wr_data_o, 32'h0);
    tick();
    ex(-1, 1, 32'h72);
    ex(-1, 1, 32'h73);
    rst_i = 1'b0;
    drive();
    for (int c = 1; c <= 10; c++) tick();
    end_test("act_leftover");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
